// File: rtl/core_pkg.sv
// Shared definitions for the accumulator-core sequencer: state encoding, opcode
// constants and the {opcode, reg, imm} field layout of a ROM word.
package core_pkg;

  localparam int CORE_ADDR_W = 5;
  localparam int CORE_REG_W  = 3;
  localparam int CORE_DATA_W = 16;

  localparam int IMM_LSB = 0;
  localparam int REG_LSB = CORE_DATA_W;
  localparam int OPC_LSB = CORE_DATA_W + CORE_REG_W;
  localparam int WORD_W  = OPC_LSB + CORE_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_JZ    = 5'h0D;
  localparam logic [4:0] OP_STORE = 5'h0E;
  localparam logic [4:0] OP_JMP   = 5'h0F;
  localparam logic [4:0] OP_HALT  = 5'h1F;

endpackage

// File: rtl/core_sequencer_if.sv
// Sequencer bus: run/step control in, ROM word and flags in, PC and datapath
// strobes plus latched instruction fields out.
interface core_sequencer_if #(
  parameter int ADDR_WIDTH    = 5,
  parameter int REG_BIT_CNT   = 3,
  parameter int DATA_WIDTH    = 16,
  parameter int COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH
);
  logic                     run;
  logic                     step_mode;
  logic                     step_req;
  logic                     step_ack;
  logic                     clr_halt;
  logic [COMBINED_DATA-1:0] rom_data;
  logic                     acc_zero;
  logic                     pc_ce;
  logic                     pc_ld;
  logic [ADDR_WIDTH-1:0]    pc_ld_addr;
  logic [ADDR_WIDTH-1:0]    opcode;
  logic [REG_BIT_CNT-1:0]   reg_sel;
  logic [DATA_WIDTH-1:0]    imm;
  logic                     acc_we;
  logic                     rf_we;
  logic                     halted;
  logic                     busy;
  logic [15:0]              retire_cnt;

  modport master (
    input  run, step_mode, step_req, clr_halt, rom_data, acc_zero,
    output step_ack, pc_ce, pc_ld, pc_ld_addr, opcode, reg_sel, imm,
           acc_we, rf_we, halted, busy, retire_cnt
  );

  modport slave (
    output run, step_mode, step_req, clr_halt, rom_data, acc_zero,
    input  step_ack, pc_ce, pc_ld, pc_ld_addr, opcode, reg_sel, imm,
           acc_we, rf_we, halted, busy, retire_cnt
  );
endinterface

// File: rtl/seq_op_class.sv
// Combinational opcode classifier; NOP is the only class with every flag low.
module seq_op_class
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = CORE_ADDR_W
) (
  input  logic [ADDR_WIDTH-1:0] opcode_i,
  output logic                  is_alu_o,
  output logic                  is_store_o,
  output logic                  is_jmp_o,
  output logic                  is_jz_o,
  output logic                  is_halt_o
);
  always_comb begin
    is_alu_o   = 1'b0;
    is_store_o = 1'b0;
    is_jmp_o   = 1'b0;
    is_jz_o    = 1'b0;
    is_halt_o  = 1'b0;
    case (opcode_i)
      ADDR_WIDTH'(OP_NOP):   ;
      ADDR_WIDTH'(OP_JZ):    is_jz_o    = 1'b1;
      ADDR_WIDTH'(OP_STORE): is_store_o = 1'b1;
      ADDR_WIDTH'(OP_JMP):   is_jmp_o   = 1'b1;
      ADDR_WIDTH'(OP_HALT):  is_halt_o  = 1'b1;
      default:               is_alu_o   = 1'b1;
    endcase
  end
endmodule

// File: rtl/core_sequencer.sv
// Four-phase instruction sequencer (FETCH, DECODE, EXEC, WB) with jumps, halt
// and single-step; all strobes are decoded from the current state.
module core_sequencer
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH    = CORE_ADDR_W,
  parameter int REG_BIT_CNT   = CORE_REG_W,
  parameter int DATA_WIDTH    = CORE_DATA_W,
  parameter int COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH
) (
  input logic             clk,
  input logic             rst,
  core_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_WB     = ST_WB;
  localparam logic [2:0] S_HALT   = ST_HALT;

  localparam int F_OPC_LSB = COMBINED_DATA - ADDR_WIDTH;
  localparam int F_REG_LSB = DATA_WIDTH;

  logic [2:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  op_q;
  logic [REG_BIT_CNT-1:0] reg_q;
  logic [DATA_WIDTH-1:0]  imm_q;
  logic                   taken_q;
  logic [15:0]            retire_q;

  logic is_alu, is_store, is_jmp, is_jz, is_halt;
  logic jump_exec;

  seq_op_class #(.ADDR_WIDTH(ADDR_WIDTH)) u_op_class (
    .opcode_i   (op_q),
    .is_alu_o   (is_alu),
    .is_store_o (is_store),
    .is_jmp_o   (is_jmp),
    .is_jz_o    (is_jz),
    .is_halt_o  (is_halt)
  );

  // JZ looks at acc_zero only while in EXEC; the decision is kept for WB.
  assign jump_exec = (state_q == S_EXEC) && (is_jmp || (is_jz && bus.acc_zero));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.step_mode && bus.run)        state_d = S_FETCH;
        else if (bus.step_mode && bus.step_req) state_d = S_FETCH;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        if (is_halt)                         state_d = S_HALT;
        else if (bus.step_mode || !bus.run)  state_d = S_IDLE;
        else                                 state_d = S_FETCH;
      end
      S_HALT:   if (bus.clr_halt) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      reg_q    <= '0;
      imm_q    <= '0;
      taken_q  <= 1'b0;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        op_q  <= bus.rom_data[F_OPC_LSB +: ADDR_WIDTH];
        reg_q <= bus.rom_data[F_REG_LSB +: REG_BIT_CNT];
        imm_q <= bus.rom_data[0 +: DATA_WIDTH];
      end
      if (state_q == S_EXEC) taken_q  <= jump_exec;
      if (state_q == S_WB)   retire_q <= retire_q + 16'd1;
    end
  end

  // A HALT retires in WB but never advances the PC, so it can be resumed in place.
  assign bus.acc_we     = (state_q == S_EXEC) && is_alu;
  assign bus.rf_we      = (state_q == S_EXEC) && is_store;
  assign bus.pc_ld      = jump_exec;
  assign bus.pc_ld_addr = imm_q[ADDR_WIDTH-1:0];
  assign bus.pc_ce      = (state_q == S_WB) && !taken_q && !is_halt;
  assign bus.step_ack   = (state_q == S_WB) && bus.step_mode && !is_halt;
  assign bus.opcode     = op_q;
  assign bus.reg_sel    = reg_q;
  assign bus.imm        = imm_q;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                          (state_q == S_EXEC)  || (state_q == S_WB);
  assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: emulates ROM and program counter, predicts each
// instruction's strobes, PC and retire count from its opcode.
module tb_core_sequencer;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_sequencer_if bus ();

  core_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [WORD_W-1:0] rom [32];
  logic [4:0]        env_pc;

  assign bus.rom_data = rom[env_pc];

  always @(posedge clk or posedge rst) begin
    if (rst)             env_pc <= 5'd0;
    else if (bus.pc_ld)  env_pc <= bus.pc_ld_addr;
    else if (bus.pc_ce)  env_pc <= env_pc + 5'd1;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] mpc;
  logic [15:0] mret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mk(input logic [4:0] op, input logic [2:0] r,
                                           input logic [15:0] im);
    logic [WORD_W-1:0] w;
    w = '0;
    w[OPC_LSB +: CORE_ADDR_W] = op;
    w[REG_LSB +: CORE_REG_W]  = r;
    w[IMM_LSB +: CORE_DATA_W] = im;
    return w;
  endfunction

  function automatic logic [4:0] rand_alu();
    logic [4:0] o;
    o = 5'($urandom_range(1, 30));
    if (o >= 5'h0D && o <= 5'h0F) o = 5'h10;
    return o;
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    logic [4:0] o;
    case ($urandom_range(0, 4))
      0:       o = 5'h00;
      1:       o = 5'h0D;
      2:       o = 5'h0E;
      3:       o = 5'h0F;
      default: o = rand_alu();
    endcase
    return mk(o, 3'($urandom), 16'($urandom));
  endfunction

  // Entered at the negedge of FETCH; leaves at the negedge after WB.
  task automatic do_instr(input logic [WORD_W-1:0] w, input logic az,
                          input logic drop_run, input logic spur);
    logic [4:0]  op;
    logic [2:0]  r;
    logic [15:0] im;
    logic alu, st, ld, hlt, ce, ack, exp_busy;
    op  = w[OPC_LSB +: 5];
    r   = w[REG_LSB +: 3];
    im  = w[IMM_LSB +: 16];
    alu = 1'b0; st = 1'b0; ld = 1'b0; hlt = 1'b0;
    case (op)
      5'h00: ;
      5'h0D: ld = az;
      5'h0E: st = 1'b1;
      5'h0F: ld = 1'b1;
      5'h1F: hlt = 1'b1;
      default: alu = 1'b1;
    endcase
    ce  = !ld && !hlt;
    rom[mpc] = w;

    chk("fetch_busy", 32'(bus.busy), 32'd1);
    chk("fetch_strobes", 32'({bus.acc_we, bus.rf_we, bus.pc_ld, bus.pc_ce, bus.step_ack}), 32'd0);
    if (spur) bus.step_req = 1'b1;

    @(negedge clk);
    chk("decode_opcode", 32'(bus.opcode), 32'(op));
    chk("decode_reg", 32'(bus.reg_sel), 32'(r));
    chk("decode_imm", 32'(bus.imm), 32'(im));
    chk("decode_strobes", 32'({bus.acc_we, bus.rf_we, bus.pc_ld, bus.pc_ce, bus.step_ack}), 32'd0);
    bus.acc_zero = az;
    bus.step_req = 1'b0;

    @(negedge clk);
    chk("exec_acc_we", 32'(bus.acc_we), 32'(alu));
    chk("exec_rf_we", 32'(bus.rf_we), 32'(st));
    chk("exec_pc_ld", 32'(bus.pc_ld), 32'(ld));
    chk("exec_pc_ce", 32'(bus.pc_ce), 32'd0);
    chk("exec_opcode", 32'(bus.opcode), 32'(op));
    if (ld) chk("exec_ld_addr", 32'(bus.pc_ld_addr), 32'(im[4:0]));
    if (st) chk("exec_reg_sel", 32'(bus.reg_sel), 32'(r));
    if (drop_run) bus.run = 1'b0;

    @(negedge clk);
    ack = bus.step_mode && !hlt;
    chk("wb_pc_ce", 32'(bus.pc_ce), 32'(ce));
    chk("wb_other", 32'({bus.acc_we, bus.rf_we, bus.pc_ld}), 32'd0);
    chk("wb_step_ack", 32'(bus.step_ack), 32'(ack));
    chk("wb_imm", 32'(bus.imm), 32'(im));
    mpc  = ld ? im[4:0] : (ce ? mpc + 5'd1 : mpc);
    mret = mret + 16'd1;
    exp_busy = !hlt && !bus.step_mode && bus.run;

    @(negedge clk);
    chk("post_retire", 32'(bus.retire_cnt), 32'(mret));
    chk("post_pc", 32'(env_pc), 32'(mpc));
    chk("post_halted", 32'(bus.halted), 32'(hlt));
    chk("post_busy", 32'(bus.busy), 32'(exp_busy));
    chk("post_step_ack", 32'(bus.step_ack), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = '0;
    bus.run = 1'b0; bus.step_mode = 1'b0; bus.step_req = 1'b0;
    bus.clr_halt = 1'b0; bus.acc_zero = 1'b0;
    mpc = 5'd0; mret = 16'd0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_retire", 32'(bus.retire_cnt), 32'd0);
    chk("rst_ir", 32'({bus.opcode, bus.reg_sel, bus.imm}), 32'd0);
    chk("rst_strobes", 32'({bus.acc_we, bus.rf_we, bus.pc_ld, bus.pc_ce, bus.step_ack}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.run = 1'b1;
    @(negedge clk);

    do_instr(mk(5'h10, 3'd0, 16'h0005), 1'b0, 1'b0, 1'b0);
    do_instr(mk(OP_STORE, 3'd3, 16'($urandom)), 1'b0, 1'b0, 1'b0);
    do_instr(mk(OP_JZ, 3'd0, 16'h0008), 1'b0, 1'b0, 1'b0);
    do_instr(mk(OP_JZ, 3'd0, 16'h000A), 1'b1, 1'b0, 1'b0);
    do_instr(mk(OP_JMP, 3'd0, 16'h0012), 1'b0, 1'b0, 1'b0);
    do_instr(mk(OP_NOP, 3'($urandom), 16'($urandom)), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      do_instr(rand_word(), 1'($urandom), 1'b0, 1'b0);

    // run dropped mid-instruction: it completes, then the core idles
    do_instr(mk(rand_alu(), 3'($urandom), 16'($urandom)), 1'b0, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_run_drop", 32'({bus.busy, bus.halted}), 32'd0);
    end
    chk("idle_retire_hold", 32'(bus.retire_cnt), 32'(mret));
    bus.run = 1'b1;
    @(negedge clk);

    do_instr(mk(OP_HALT, 3'd0, 16'($urandom)), 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("halt_hold", 32'({bus.halted, bus.busy, bus.pc_ce}), 32'b100);
      chk("halt_pc", 32'(env_pc), 32'(mpc));
    end
    bus.run = 1'b0;
    bus.clr_halt = 1'b1;
    @(negedge clk);
    bus.clr_halt = 1'b0;
    chk("clr_halt_state", 32'({bus.halted, bus.busy}), 32'd0);
    chk("clr_halt_pc", 32'(env_pc), 32'(mpc));

    bus.step_mode = 1'b1;
    @(negedge clk);
    chk("step_idle_wait", 32'(bus.busy), 32'd0);
    bus.step_req = 1'b1;
    @(negedge clk);
    bus.step_req = 1'b0;
    do_instr(mk(rand_alu(), 3'($urandom), 16'($urandom)), 1'($urandom), 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("step_one_only", 32'({bus.busy, bus.step_ack}), 32'd0);
    end
    chk("step_retire", 32'(bus.retire_cnt), 32'(mret));

    // reset while in EXEC
    bus.step_req = 1'b1;
    @(negedge clk);
    bus.step_req = 1'b0;
    rom[mpc] = mk(5'h12, 3'd1, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    chk("exec_before_rst", 32'(bus.acc_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_exec_strobes", 32'({bus.acc_we, bus.rf_we, bus.pc_ld, bus.pc_ce}), 32'd0);
    chk("rst_exec_busy", 32'(bus.busy), 32'd0);
    chk("rst_exec_retire", 32'(bus.retire_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mpc = 5'd0; mret = 16'd0;
    @(negedge clk);
    chk("rst_exec_idle", 32'({bus.busy, bus.halted, bus.opcode}), 32'd0);
    chk("rst_exec_pc", 32'(env_pc), 32'(mpc));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
